// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipe_stage pipeline register slice.
//   state_t      : occupancy state (EMPTY / FULL / SKID)
//   DEF_*        : default widths used by pipe_stage and pipe_entry
//   BUBBLE_*     : bubble behaviour selector values for BUBBLE_MODE
//   drop_count() : number of live entries a flush throws away
package pipe_pkg;

  localparam int DEF_DATA_W = 154;
  localparam int DEF_CTRL_W = 10;
  localparam int DEF_CNT_W  = 8;

  // Bubble behaviour when the stage runs empty.
  localparam int BUBBLE_ZERO = 0;  // ctrl and data forced to zero
  localparam int BUBBLE_HOLD = 1;  // ctrl forced to zero, data keeps last value

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // An entry leaving through the output in the same cycle as a flush
  // was delivered, so it is not counted as dropped.
  function automatic logic [1:0] drop_count(input state_t st, input logic consume);
    logic [1:0] n;
    case (st)
      ST_FULL: n = consume ? 2'd0 : 2'd1;
      ST_SKID: n = consume ? 2'd1 : 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// pipe_entry -- one ctrl+data storage slot of the pipeline stage.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (clears slot)
//   load               : capture d_ctrl/d_data (wins over the clears)
//   clear_ctrl         : zero the ctrl field
//   clear_data         : zero the data field
//   d_ctrl, d_data     : values to capture
//   q_ctrl, q_data     : stored values
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // ctrl and data have independent clears so the owner can bubble the
  // control bundle while leaving the payload untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else begin
      if (load)            q_ctrl <= d_ctrl;
      else if (clear_ctrl) q_ctrl <= '0;
      if (load)            q_data <= d_data;
      else if (clear_data) q_data <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage -- valid/ready pipeline register with one skid entry and flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready = skid not occupied)
//   in_ctrl, in_data    : upstream control bundle and payload
//   flush               : discard held and incoming entries
//   out_valid/out_ready : downstream handshake
//   out_ctrl, out_data  : output entry, always taken from the main slot
//   drop_cnt            : saturating count of valid entries lost to flush
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CTRL_W      = DEF_CTRL_W,
  parameter int BUBBLE_MODE = BUBBLE_ZERO,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_t state, state_next;

  logic accept, consume;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic [CTRL_W-1:0] skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] skid_data, main_d_data;
  logic [CNT_W:0]    drop_sum;

  // Both handshake outputs decode straight from the state register.
  assign in_ready  = (state != ST_SKID);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_FULL;
            main_load  = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_next = ST_SKID;
            skid_load  = 1'b1;
          end else if (consume) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the skid entry can advance.
          if (consume) begin
            state_next     = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Main slot drives the outputs; in hold-bubble mode its payload is
  // never cleared so out_data keeps the last value while empty.
  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (main_load),
    .clear_ctrl (main_clear),
    .clear_data (main_clear && (BUBBLE_MODE == BUBBLE_ZERO)),
    .d_ctrl     (main_d_ctrl),
    .d_data     (main_d_data),
    .q_ctrl     (out_ctrl),
    .q_data     (out_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear_ctrl (skid_clear),
    .clear_data (skid_clear),
    .d_ctrl     (in_ctrl),
    .d_data     (in_data),
    .q_ctrl     (skid_ctrl),
    .q_data     (skid_data)
  );

  // One spare bit catches the overflow; 2 + (2^CNT_W - 1) always fits.
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(drop_count(state, consume));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: default parameters (zero bubble, 8-bit drop counter)
  logic         in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [9:0]   in_ctrl0, out_ctrl0;
  logic [153:0] in_data0, out_data0;
  logic [7:0]   drop_cnt0;

  // dut1: hold bubble, 16-bit payload, 2-bit drop counter
  logic         in_valid1, in_ready1, flush1, out_valid1, out_ready1;
  logic [9:0]   in_ctrl1, out_ctrl1;
  logic [15:0]  in_data1, out_data1;
  logic [1:0]   drop_cnt1;

  pipe_stage dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .drop_cnt(drop_cnt0)
  );

  pipe_stage #(.DATA_W(16), .CTRL_W(10), .BUBBLE_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .flush(flush1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .drop_cnt(drop_cnt1)
  );

  typedef struct { logic [9:0] c; logic [153:0] d; } ent0_t;
  typedef struct { logic [9:0] c; logic [15:0]  d; } ent1_t;
  ent0_t q0[$];
  ent1_t q1[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitors: every consumed output must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      $display("dut0 out ctrl=%h data=%h", out_ctrl0, out_data0);
      if (q0.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut0_unexpected: got ctrl=%h data=%h required none", out_ctrl0, out_data0);
      end else begin
        ent0_t e;
        e = q0.pop_front();
        chk("dut0_sb_ctrl", 256'(out_ctrl0), 256'(e.c));
        chk("dut0_sb_data", 256'(out_data0), 256'(e.d));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      $display("dut1 out ctrl=%h data=%h", out_ctrl1, out_data1);
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut1_unexpected: got ctrl=%h data=%h required none", out_ctrl1, out_data1);
      end else begin
        ent1_t e;
        e = q1.pop_front();
        chk("dut1_sb_ctrl", 256'(out_ctrl1), 256'(e.c));
        chk("dut1_sb_data", 256'(out_data1), 256'(e.d));
      end
    end
  end

  task automatic send0(input logic [9:0] c, input logic [153:0] d, input bit expect_out);
    in_valid0 = 1'b1;
    in_ctrl0  = c;
    in_data0  = d;
    if (expect_out) q0.push_back('{c, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] drop_exp [4];
    drop_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

    in_valid0 = 0; in_ctrl0 = '0; in_data0 = '0; flush0 = 0; out_ready0 = 0;
    in_valid1 = 0; in_ctrl1 = '0; in_data1 = '0; flush1 = 0; out_ready1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    chk("rst_out_valid", 256'(out_valid0), 256'(1'b0));
    chk("rst_in_ready",  256'(in_ready0),  256'(1'b1));
    chk("rst_out_ctrl",  256'(out_ctrl0),  256'(10'h0));
    chk("rst_out_data",  256'(out_data0),  256'(154'h0));
    chk("rst_drop_cnt",  256'(drop_cnt0),  256'(8'h0));
    chk("rst1_out_valid", 256'(out_valid1), 256'(1'b0));
    rst_n = 1'b1;

    // Single entry, one-cycle latency
    step();
    send0(10'h155, 154'hA5, 1'b1);
    out_ready0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    sample();
    chk("lat_out_valid", 256'(out_valid0), 256'(1'b1));
    chk("lat_in_ready",  256'(in_ready0),  256'(1'b1));
    chk("lat_out_ctrl",  256'(out_ctrl0),  256'(10'h155));
    chk("lat_out_data",  256'(out_data0),  256'(154'hA5));
    step();
    sample();
    chk("bubble0_valid", 256'(out_valid0), 256'(1'b0));
    chk("bubble0_ctrl",  256'(out_ctrl0),  256'(10'h0));
    chk("bubble0_data",  256'(out_data0),  256'(154'h0));

    // Three-entry stream with backpressure into the skid slot
    step();
    send0(10'h001, 154'h111, 1'b1);
    step();
    send0(10'h002, 154'h222, 1'b1);
    out_ready0 = 1'b0;
    step();
    send0(10'h003, 154'h333, 1'b0);
    sample();
    chk("skid_in_ready",  256'(in_ready0),  256'(1'b0));
    chk("skid_out_valid", 256'(out_valid0), 256'(1'b1));
    chk("skid_out_ctrl",  256'(out_ctrl0),  256'(10'h001));
    step();
    out_ready0 = 1'b1;
    q0.push_back('{10'h003, 154'h333});
    sample();
    chk("skid_hold_in_ready", 256'(in_ready0), 256'(1'b0));
    step();
    sample();
    chk("unskid_in_ready", 256'(in_ready0), 256'(1'b1));
    chk("unskid_out_ctrl", 256'(out_ctrl0), 256'(10'h002));
    step();
    in_valid0 = 1'b0;
    sample();
    chk("stream_last_ctrl", 256'(out_ctrl0), 256'(10'h003));
    step();
    sample();
    chk("stream_drained", 256'(out_valid0), 256'(1'b0));

    // Flush while in SKID with a valid input present
    step();
    out_ready0 = 1'b0;
    send0(10'h004, 154'h444, 1'b0);
    step();
    send0(10'h005, 154'h555, 1'b0);
    step();
    send0(10'h006, 154'h666, 1'b0);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    in_valid0 = 1'b0;
    sample();
    chk("flush_out_valid", 256'(out_valid0), 256'(1'b0));
    chk("flush_out_ctrl",  256'(out_ctrl0),  256'(10'h0));
    chk("flush_out_data",  256'(out_data0),  256'(154'h0));
    chk("flush_drop_cnt",  256'(drop_cnt0),  256'(8'd2));
    chk("flush_in_ready",  256'(in_ready0),  256'(1'b1));
    step();
    sample();
    chk("flush_no_capture", 256'(out_valid0), 256'(1'b0));

    // Asynchronous reset while FULL
    step();
    send0(10'h007, 154'h777, 1'b0);
    step();
    in_valid0 = 1'b0;
    sample();
    chk("full_before_rst", 256'(out_valid0), 256'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(out_valid0), 256'(1'b0));
    chk("arst_in_ready",  256'(in_ready0),  256'(1'b1));
    chk("arst_drop_cnt",  256'(drop_cnt0),  256'(8'd0));
    chk("arst_out_ctrl",  256'(out_ctrl0),  256'(10'h0));
    step();
    rst_n = 1'b1;

    // Hold-bubble mode: payload survives after the entry leaves
    step();
    in_valid1 = 1'b1; in_ctrl1 = 10'h0F3; in_data1 = 16'h003C; out_ready1 = 1'b1;
    q1.push_back('{10'h0F3, 16'h003C});
    step();
    in_valid1 = 1'b0;
    step();
    sample();
    chk("hold_out_valid", 256'(out_valid1), 256'(1'b0));
    chk("hold_out_ctrl",  256'(out_ctrl1),  256'(10'h0));
    chk("hold_out_data",  256'(out_data1),  256'(16'h003C));
    step();
    sample();
    chk("hold_out_data_idle", 256'(out_data1), 256'(16'h003C));

    // Saturating drop counter, one discarded entry per flush
    out_ready1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      in_valid1 = 1'b1;
      in_ctrl1  = 10'(k + 1);
      in_data1  = 16'(16'h0100 + k);
      step();
      in_valid1 = 1'b0;
      flush1    = 1'b1;
      step();
      flush1 = 1'b0;
      sample();
      $display("dut1 flush %0d drop_cnt=%0d", k, drop_cnt1);
      chk($sformatf("sat_drop_cnt_%0d", k), 256'(drop_cnt1), 256'(drop_exp[k]));
    end
    chk("sat_out_valid", 256'(out_valid1), 256'(1'b0));

    // Every expected entry must have come out
    step();
    sample();
    chk("dut0_sb_empty", 256'(q0.size()), 256'(0));
    chk("dut1_sb_empty", 256'(q1.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
